// File: rtl/qrisc32_if_prefetch.sv
// Qrisc32 instruction fetch with prefetch FIFO: a pipelined Avalon-MM read master
// feeding decode over valid/ready, with redirect flush and stale-response squashing.
module qrisc32_if_prefetch #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  input  logic        new_address_valid,
  input  logic [31:0] new_address,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] MAX_W   = CW'(MAX_OUTSTANDING);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   r_fetch_pc, r_resp_pc, r_last_pc, r_avm_address;
  logic          r_avm_read;
  logic [CW-1:0] r_outstanding, r_discard, r_count;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [31:0]   r_mem_pc    [DEPTH];
  logic [31:0]   r_mem_instr [DEPTH];

  logic [31:0]   w_target, w_base_pc;
  logic          w_accept, w_held, w_push, w_pop, w_head_valid, w_valid;
  logic          w_credit, w_raise;
  logic [CW-1:0] w_out_next, w_count_next, w_discard_next;
  logic          w_unused_bits;

  assign w_unused_bits = ^new_address[1:0];

  always_comb begin
    w_target       = {new_address[31:2], 2'b00};
    w_accept       = r_avm_read & ~avm_waitrequest;
    w_held         = r_avm_read & avm_waitrequest;
    w_push         = avm_readdatavalid & ~new_address_valid & (r_discard == '0);
    w_head_valid   = (r_count != '0);
    w_valid        = w_head_valid & ~new_address_valid;
    w_pop          = w_valid & instr_ready;
    w_out_next     = r_outstanding + CW'(w_accept) - CW'(avm_readdatavalid);
    w_count_next   = new_address_valid ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
    // A held read will be accepted later with the old address, so it is stale too.
    w_discard_next = r_discard;
    if (new_address_valid)
      w_discard_next = w_out_next + CW'(w_held);
    else if (avm_readdatavalid && (r_discard != '0))
      w_discard_next = r_discard - CW'(1);
    w_credit  = (w_out_next < MAX_W) &&
                (({1'b0, w_out_next} + {1'b0, w_count_next}) < DEPTH_W);
    w_raise   = ~w_held & w_credit;
    w_base_pc = new_address_valid ? w_target : r_fetch_pc;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_avm_read    <= 1'b0;
      r_avm_address <= RESET_PC;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_last_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_outstanding <= w_out_next;
      r_discard     <= w_discard_next;
      r_count       <= w_count_next;
      r_fetch_pc    <= w_base_pc + (w_raise ? 32'd4 : 32'd0);
      if (!w_held) begin
        r_avm_read    <= w_credit;
        r_avm_address <= w_base_pc;
      end
      if (new_address_valid) begin
        r_resp_pc <= w_target;
        r_rd_ptr  <= r_wr_ptr;
      end else begin
        if (w_push) begin
          r_resp_pc <= r_resp_pc + 32'd4;
          r_last_pc <= r_resp_pc;
          r_wr_ptr  <= r_wr_ptr + AW'(1);
        end
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // NOTE: FIFO storage is not reset; entries are only read once r_count marks them written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_resp_pc;
      r_mem_instr[r_wr_ptr] <= avm_readdata;
    end
  end

  always_comb begin
    avm_read    = r_avm_read;
    avm_address = r_avm_address;
    instr_valid = w_valid;
    instruction = w_valid ? r_mem_instr[r_rd_ptr] : 32'h0;
    pc          = w_head_valid ? r_mem_pc[r_rd_ptr] : r_last_pc;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(w_push && !w_pop && (r_count == CW'(DEPTH))));

endmodule

// File: tb/tb_qrisc32_if_prefetch.sv
// Bench for qrisc32_if_prefetch: Avalon slave model, directed scenarios and a
// randomized phase, with a scoreboard of expected {pc, instruction} pairs.
`timescale 1ns/1ps
module tb_qrisc32_if_prefetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_readdatavalid = 1'b0;
  logic        new_address_valid = 1'b0;
  logic [31:0] new_address = 32'h0;
  logic        instr_ready = 1'b1;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] pc;

  qrisc32_if_prefetch #(
    .RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .new_address_valid(new_address_valid), .new_address(new_address),
    .instr_ready(instr_ready), .instr_valid(instr_valid),
    .instruction(instruction), .pc(pc)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_pc;
  int          n_cmp = 0, n_fail = 0, n_pop = 0, n_resp = 0;

  // Slave behaviour knobs
  int          wait_pct = 0, resp_pct = 100, ws_left = 0;
  bit          resp_hold = 1'b0;
  logic [31:0] ws_addr = 32'hFFFF_FFFF;
  logic [31:0] pend_q[$];
  logic [31:0] acc_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: after reset or a redirect, decode sees target, target+4, ... and
  // each word is whatever memory holds there (address + 0x100).
  function automatic void model_refill();
    exp_t e;
    while (exp_q.size() < 8) begin
      e.pc    = model_pc;
      e.instr = model_pc + 32'h100;
      exp_q.push_back(e);
      model_pc += 32'd4;
    end
  endfunction

  function automatic void model_restart(input logic [31:0] start);
    exp_q.delete();
    model_pc = {start[31:2], 2'b00};
    model_refill();
  endfunction

  // Monitor: compare each handed-off instruction against the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (instr_valid && instr_ready) begin
          e = exp_q.pop_front();
          check("pop_pc", pc, e.pc);
          check("pop_instr", instruction, e.instr);
          n_pop++;
          model_refill();
        end
        if (!instr_valid) check("nop_when_invalid", instruction, 32'h0);
      end
    end
  end

  // Slave sampler: record accepts and police the Avalon hold rule.
  initial begin : slave_sample
    bit          prev_held;
    logic [31:0] prev_addr;
    prev_held = 1'b0;
    prev_addr = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend_q.delete();
        acc_log.delete();
        prev_held = 1'b0;
      end else begin
        if (prev_held) begin
          check("hold_read", {31'b0, avm_read}, 32'd1);
          check("hold_addr", avm_address, prev_addr);
        end
        if (avm_read) check("addr_aligned", {30'b0, avm_address[1:0]}, 32'd0);
        if (avm_read && !avm_waitrequest) begin
          pend_q.push_back(avm_address);
          acc_log.push_back(avm_address);
        end
        prev_held = avm_read && avm_waitrequest;
        prev_addr = avm_address;
      end
    end
  end

  // Slave driver: in-order responses at least one cycle after accept.
  initial begin : slave_drive
    logic [31:0] a;
    forever begin
      @(posedge clk);
      #1;
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'h0;
      if (reset_n && !resp_hold && pend_q.size() > 0 && $urandom_range(99, 0) < resp_pct) begin
        a = pend_q.pop_front();
        avm_readdatavalid = 1'b1;
        avm_readdata      = a + 32'h100;
        n_resp++;
      end
      if (avm_read && avm_address == ws_addr && ws_left > 0) begin
        avm_waitrequest = 1'b1;
        ws_left--;
      end else begin
        avm_waitrequest = ($urandom_range(99, 0) < wait_pct);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Leaves the bench at the first cycle with reset_n driven high.
  task automatic apply_reset(input bit rdy);
    tick();
    reset_n           = 1'b0;
    instr_ready       = rdy;
    new_address_valid = 1'b0;
    model_restart(RESET_PC);
    tick();
    neg();
    check("rst_avm_read", {31'b0, avm_read}, 32'd0);
    check("rst_avm_address", avm_address, RESET_PC);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instruction", instruction, 32'h0);
    check("rst_pc", pc, RESET_PC);
    tick();
    reset_n = 1'b1;
  endtask

  task automatic startup_checks();
    neg();
    check("read_before_release", {31'b0, avm_read}, 32'd0);
    tick(); neg();
    check("first_read", {31'b0, avm_read}, 32'd1);
    check("first_address", avm_address, RESET_PC);
    tick(); neg();
    check("valid_too_early", {31'b0, instr_valid}, 32'd0);
    tick(); neg();
    check("first_valid_latency", {31'b0, instr_valid}, 32'd1);
    check("first_pc", pc, RESET_PC);
  endtask

  initial begin : stimulus
    int          found, v, r0, p0, held_cnt;
    logic [31:0] addr;

    // Reset, latency and sustained one-per-cycle delivery
    apply_reset(1'b1);
    startup_checks();
    v = 0;
    for (int i = 0; i < 16; i++) begin
      tick(); neg();
      if (instr_valid) v++;
    end
    check("sustained_rate", v, 16);

    // Redirect with no held read
    tick();
    new_address_valid = 1'b1;
    new_address       = 32'h0000_1000;
    model_restart(new_address);
    neg();
    check("redirect_gates_valid", {31'b0, instr_valid}, 32'd0);
    check("redirect_gates_instr", instruction, 32'h0);
    tick();
    new_address_valid = 1'b0;
    neg();
    check("redirect_issue_read", {31'b0, avm_read}, 32'd1);
    check("redirect_issue_addr", avm_address, 32'h0000_1000);
    for (int i = 0; i < 10; i++) begin tick(); neg(); end

    // Waitrequest held three cycles on 0x8
    apply_reset(1'b1);
    ws_addr  = 32'h8;
    ws_left  = 3;
    held_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      neg();
      if (avm_read && avm_address == 32'h8 && avm_waitrequest) held_cnt++;
      tick();
    end
    check("ws_held_cycles", held_cnt, 3);
    if (acc_log.size() >= 4) begin
      check("ws_accept_8", acc_log[2], 32'h8);
      check("ws_accept_c", acc_log[3], 32'hC);
    end else begin
      check("ws_accept_count", acc_log.size(), 4);
    end

    // Decode stalled: credits fill the FIFO, then release
    apply_reset(1'b0);
    r0 = n_resp;
    for (int i = 0; i < 12; i++) begin tick(); neg(); end
    check("stall_buffered", n_resp - r0, 4);
    check("stall_read_low", {31'b0, avm_read}, 32'd0);
    check("stall_head_valid", {31'b0, instr_valid}, 32'd1);
    check("stall_head_pc", pc, RESET_PC);
    tick();
    instr_ready = 1'b1;
    v = 0;
    for (int i = 0; i < 4; i++) begin
      neg();
      if (instr_valid) v++;
      tick();
    end
    check("release_burst", v, 4);

    // Fill again, then reset mid-stream with a full FIFO
    instr_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin tick(); neg(); end
    check("full_before_reset", {31'b0, instr_valid}, 32'd1);
    apply_reset(1'b1);
    startup_checks();
    for (int i = 0; i < 6; i++) begin tick(); neg(); end

    // Redirect with two reads in flight
    apply_reset(1'b1);
    resp_hold = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(); neg(); end
    check("credit_limit_read", {31'b0, avm_read}, 32'd0);
    check("credit_limit_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    new_address_valid = 1'b1;
    new_address       = 32'h0000_0203;
    model_restart(new_address);
    tick();
    new_address_valid = 1'b0;
    resp_hold         = 1'b0;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      neg();
      if (instr_valid) begin found = 1; break; end
      tick();
    end
    check("redir_inflight_found", found, 1);
    check("redir_inflight_pc", pc, 32'h0000_0200);
    check("redir_inflight_instr", instruction, 32'h0000_0300);

    // Redirect while 0x10 is held under waitrequest
    apply_reset(1'b1);
    ws_addr = 32'h10;
    ws_left = 3;
    found   = 0;
    for (int i = 0; i < 20; i++) begin
      neg();
      if (avm_read && avm_address == 32'h10 && avm_waitrequest) begin found = 1; break; end
      tick();
    end
    check("held_seen", found, 1);
    tick();
    new_address_valid = 1'b1;
    new_address       = 32'h0000_0040;
    model_restart(new_address);
    neg();
    check("held_read_kept", {31'b0, avm_read}, 32'd1);
    check("held_addr_kept", avm_address, 32'h0000_0010);
    tick();
    new_address_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin neg(); tick(); end
    if (acc_log.size() >= 6) begin
      check("held_accept_old", acc_log[4], 32'h10);
      check("held_accept_target", acc_log[5], 32'h40);
    end else begin
      check("held_accept_count", acc_log.size(), 6);
    end

    // Randomized traffic: stalls, waitstates, variable latency, redirects, wrap
    apply_reset(1'b1);
    wait_pct = 20;
    resp_pct = 60;
    p0 = n_pop;
    for (int i = 0; i < 3000; i++) begin
      tick();
      instr_ready = ($urandom_range(99, 0) < 70);
      if ($urandom_range(99, 0) < 3) begin
        addr = ($urandom_range(9, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                           : 32'($urandom);
        new_address_valid = 1'b1;
        new_address       = addr;
        model_restart(addr);
      end else begin
        new_address_valid = 1'b0;
      end
      neg();
    end
    tick();
    new_address_valid = 1'b0;
    check("random_progress", {31'b0, (n_pop - p0) > 200}, 32'd1);
    wait_pct = 0;
    resp_pct = 100;
    for (int i = 0; i < 5; i++) begin neg(); tick(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
